mem_axi_bridge: RTL and testbench

// - Parametrised bridge from the core's mem_interface (mem_slave side) to an AXI4 master.
// - Supports multi-ID reads, INCR bursts up to 32 words, single-beat byte-strobed writes and

---
 rtl/mem_axi_bridge.sv | 228 ++++++++++++++++++++++
 tb/tb_mem_axi_bridge.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_axi_bridge.sv
// mem_axi_bridge: core mem_slave request port to a 32-bit AXI4 master, one command in flight.
// Define MEM_AXI_ERR_CAPTURE_EN to add first-error capture (err_valid/err_addr/err_clr).
module mem_axi_bridge #(
  parameter int         ID_W       = 2,
  parameter int         MAX_READS  = 4,
  parameter int         MAX_WRITES = 4,
  parameter logic [3:0] AXI_CACHE  = 4'b0011
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_request,
  input  logic [29:0]     mem_addr,
  input  logic [4:0]      mem_rlen,
  input  logic            mem_rnw,
  input  logic            mem_rmw,
  input  logic [3:0]      mem_wbe,
  input  logic [31:0]     mem_wdata,
  input  logic [ID_W-1:0] mem_id,
  output logic            mem_ack,
  output logic            mem_rvalid,
  output logic [31:0]     mem_rdata,
  output logic [ID_W-1:0] mem_rid,
  output logic            mem_inv,
  output logic [29:0]     mem_inv_addr,
  output logic            mem_write_outstanding,
  output logic            axi_arvalid,
  input  logic            axi_arready,
  output logic [31:0]     axi_araddr,
  output logic [7:0]      axi_arlen,
  output logic [2:0]      axi_arsize,
  output logic [1:0]      axi_arburst,
  output logic            axi_arlock,
  output logic [3:0]      axi_arcache,
  output logic [5:0]      axi_arid,
  output logic            axi_awvalid,
  input  logic            axi_awready,
  output logic [31:0]     axi_awaddr,
  output logic [7:0]      axi_awlen,
  output logic [2:0]      axi_awsize,
  output logic [1:0]      axi_awburst,
  output logic            axi_awlock,
  output logic [3:0]      axi_awcache,
  output logic [5:0]      axi_awid,
  output logic            axi_wvalid,
  input  logic            axi_wready,
  output logic [31:0]     axi_wdata,
  output logic [3:0]      axi_wstrb,
  output logic            axi_wlast,
  input  logic            axi_bvalid,
  output logic            axi_bready,
  input  logic [5:0]      axi_bid,
  input  logic [1:0]      axi_bresp,
  input  logic            axi_rvalid,
  output logic            axi_rready,
  input  logic [5:0]      axi_rid,
  input  logic [31:0]     axi_rdata,
  input  logic [1:0]      axi_rresp,
  input  logic            axi_rlast
`ifdef MEM_AXI_ERR_CAPTURE_EN
  ,
  output logic            err_valid,
  output logic [31:0]     err_addr,
  input  logic            err_clr
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, AR = 2'd1, AW_W = 2'd2} state_t;

  localparam logic [4:0] MAX_RD = 5'(MAX_READS);
  localparam logic [4:0] MAX_WR = 5'(MAX_WRITES);

  state_t          state, state_nxt;
  logic            run;
  logic [4:0]      read_cnt, write_cnt;
  logic [29:0]     cmd_addr;
  logic [4:0]      cmd_rlen;
  logic            cmd_rmw;
  logic [3:0]      cmd_wbe;
  logic [31:0]     cmd_wdata;
  logic [ID_W-1:0] cmd_id;
  logic            aw_done, w_done;
  logic            ar_hs, aw_hs, w_hs, r_hs, b_hs;
  logic            rd_dec, wr_inc, wr_dec, rd_credit, wr_credit;
  logic            unused_bits;

  assign r_hs   = axi_rvalid & run;
  assign b_hs   = axi_bvalid & run;
  assign ar_hs  = axi_arvalid & axi_arready;
  assign aw_hs  = axi_awvalid & axi_awready;
  assign w_hs   = axi_wvalid & axi_wready;
  assign rd_dec = r_hs & axi_rlast & (read_cnt != 5'd0);
  assign wr_dec = b_hs & (write_cnt != 5'd0);
  assign wr_inc = mem_ack & ~mem_rnw;
  // A completion in the same cycle frees its credit for a waiting request.
  assign rd_credit = (read_cnt - {4'd0, rd_dec}) < MAX_RD;
  assign wr_credit = (write_cnt - {4'd0, wr_dec}) < MAX_WR;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    mem_ack     = 1'b0;
    axi_arvalid = 1'b0;
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    case (state)
      IDLE: begin
        mem_ack = run & mem_request & (mem_rnw ? rd_credit : wr_credit);
        if (mem_ack) state_nxt = mem_rnw ? AR : AW_W;
      end
      AR: begin
        axi_arvalid = 1'b1;
        if (axi_arready) state_nxt = IDLE;
      end
      AW_W: begin
        axi_awvalid = ~aw_done;
        axi_wvalid  = ~w_done;
        if ((aw_done | axi_awready) & (w_done | axi_wready)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run       <= 1'b0;
      read_cnt  <= 5'd0;
      write_cnt <= 5'd0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      cmd_addr  <= '0;
      cmd_rlen  <= '0;
      cmd_rmw   <= 1'b0;
      cmd_wbe   <= '0;
      cmd_wdata <= '0;
      cmd_id    <= '0;
    end else begin
      run       <= 1'b1;
      read_cnt  <= read_cnt + {4'd0, ar_hs} - {4'd0, rd_dec};
      write_cnt <= write_cnt + {4'd0, wr_inc} - {4'd0, wr_dec};
      if (mem_ack) begin
        cmd_addr  <= mem_addr;
        cmd_rlen  <= mem_rlen;
        cmd_rmw   <= mem_rmw;
        cmd_wbe   <= mem_wbe;
        cmd_wdata <= mem_wdata;
        cmd_id    <= mem_id;
        aw_done   <= 1'b0;
        w_done    <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
    end
  end

  assign axi_araddr  = {cmd_addr, 2'b00};
  assign axi_arlen   = {3'b000, cmd_rlen};
  assign axi_arsize  = 3'b010;
  assign axi_arburst = 2'b01;
  assign axi_arlock  = cmd_rmw;
  assign axi_arcache = AXI_CACHE;
  assign axi_arid    = {{(6-ID_W){1'b0}}, cmd_id};
  assign axi_awaddr  = {cmd_addr, 2'b00};
  assign axi_awlen   = 8'd0;
  assign axi_awsize  = 3'b010;
  assign axi_awburst = 2'b01;
  assign axi_awlock  = cmd_rmw;
  assign axi_awcache = AXI_CACHE;
  assign axi_awid    = {{(6-ID_W){1'b0}}, cmd_id};
  assign axi_wdata   = cmd_wdata;
  assign axi_wstrb   = cmd_wbe;
  assign axi_wlast   = 1'b1;
  assign axi_rready  = run;
  assign axi_bready  = run;

  assign mem_rvalid            = r_hs;
  assign mem_rdata             = axi_rdata;
  assign mem_rid               = axi_rid[ID_W-1:0];
  assign mem_inv               = 1'b0;
  assign mem_inv_addr          = '0;
  assign mem_write_outstanding = (write_cnt != 5'd0) | (state == AW_W);

  assign unused_bits = ^{axi_bid, axi_rid[5:ID_W], axi_rresp, axi_bresp};

  assert property (@(posedge clk) disable iff (!rst_n) !(r_hs && axi_rlast && read_cnt == 5'd0));
  assert property (@(posedge clk) disable iff (!rst_n) !(b_hs && write_cnt == 5'd0));

`ifdef MEM_AXI_ERR_CAPTURE_EN
  localparam int WP_W = (MAX_WRITES > 1) ? $clog2(MAX_WRITES) : 1;
  localparam logic [WP_W-1:0] WP_LAST = WP_W'(MAX_WRITES - 1);

  logic [31:0]     rd_tab  [2**ID_W];
  logic [31:0]     wr_fifo [2**WP_W];
  logic [WP_W-1:0] wr_wp, wr_rp;
  logic            r_err, b_err;

  assign r_err = r_hs & axi_rresp[1];
  assign b_err = wr_dec & axi_bresp[1];

  always_ff @(posedge clk) begin
    if (ar_hs)  rd_tab[cmd_id]  <= {cmd_addr, 2'b00};
    if (wr_inc) wr_fifo[wr_wp]  <= {mem_addr, 2'b00};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_wp     <= '0;
      wr_rp     <= '0;
      err_valid <= 1'b0;
      err_addr  <= '0;
    end else begin
      if (wr_inc) wr_wp <= (wr_wp == WP_LAST) ? '0 : wr_wp + 1'b1;
      if (wr_dec) wr_rp <= (wr_rp == WP_LAST) ? '0 : wr_rp + 1'b1;
      if (err_clr) begin
        err_valid <= 1'b0;
      end else if (!err_valid && (r_err || b_err)) begin
        err_valid <= 1'b1;
        err_addr  <= r_err ? rd_tab[axi_rid[ID_W-1:0]] : wr_fifo[wr_rp];
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_axi_bridge.sv
// Bench for mem_axi_bridge: directed stimulus, a queue/counter model checked every cycle,
// and literal expectations for the key scenarios (error checks only with MEM_AXI_ERR_CAPTURE_EN).
module tb_mem_axi_bridge;
  localparam int MAX_READS  = 4;
  localparam int MAX_WRITES = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic mem_request = 0, mem_rnw = 0, mem_rmw = 0;
  logic [29:0] mem_addr = '0;
  logic [4:0]  mem_rlen = '0;
  logic [3:0]  mem_wbe = '0;
  logic [31:0] mem_wdata = '0;
  logic [1:0]  mem_id = '0;
  logic mem_ack, mem_rvalid, mem_inv, mem_write_outstanding;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rid;
  logic [29:0] mem_inv_addr;
  logic axi_arvalid, axi_arready = 0, axi_arlock, axi_awvalid, axi_awready = 0, axi_awlock;
  logic [31:0] axi_araddr, axi_awaddr, axi_wdata;
  logic [7:0]  axi_arlen, axi_awlen;
  logic [2:0]  axi_arsize, axi_awsize;
  logic [1:0]  axi_arburst, axi_awburst;
  logic [3:0]  axi_arcache, axi_awcache, axi_wstrb;
  logic [5:0]  axi_arid, axi_awid;
  logic axi_wvalid, axi_wready = 0, axi_wlast, axi_bvalid = 0, axi_bready;
  logic [5:0]  axi_bid = '0, axi_rid = '0;
  logic [1:0]  axi_bresp = '0, axi_rresp = '0;
  logic axi_rvalid = 0, axi_rready, axi_rlast = 0;
  logic [31:0] axi_rdata = '0;
`ifdef MEM_AXI_ERR_CAPTURE_EN
  logic err_valid, err_clr = 0;
  logic [31:0] err_addr;
`endif

  int checks = 0, failures = 0;

  mem_axi_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .mem_request(mem_request), .mem_addr(mem_addr), .mem_rlen(mem_rlen), .mem_rnw(mem_rnw),
    .mem_rmw(mem_rmw), .mem_wbe(mem_wbe), .mem_wdata(mem_wdata), .mem_id(mem_id),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rid(mem_rid),
    .mem_inv(mem_inv), .mem_inv_addr(mem_inv_addr), .mem_write_outstanding(mem_write_outstanding),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
    .axi_arlen(axi_arlen), .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
    .axi_arlock(axi_arlock), .axi_arcache(axi_arcache), .axi_arid(axi_arid),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
    .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
    .axi_awlock(axi_awlock), .axi_awcache(axi_awcache), .axi_awid(axi_awid),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
    .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bid(axi_bid), .axi_bresp(axi_bresp),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rid(axi_rid), .axi_rdata(axi_rdata),
    .axi_rresp(axi_rresp), .axi_rlast(axi_rlast)
`ifdef MEM_AXI_ERR_CAPTURE_EN
    , .err_valid(err_valid), .err_addr(err_addr), .err_clr(err_clr)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Model: outstanding counts, one pending command with its channel flags.
  int m_rd = 0, m_wr = 0, m_busy = 0;
  bit m_ready = 0, m_ar = 0, m_aw = 0, m_w = 0;
  logic [29:0] m_addr;
  logic [4:0]  m_rlen;
  logic        m_rmw;
  logic [3:0]  m_wbe;
  logic [31:0] m_wdata;
  logic [1:0]  m_id;
`ifdef MEM_AXI_ERR_CAPTURE_EN
  logic [31:0] m_rtab [int];
  logic [31:0] m_wq [$];
  bit          m_ev = 0;
  logic [31:0] m_ea = '0;
`endif

  always @(negedge clk) begin
    bit rlast_hs, bhs, rcred, wcred, e_ack;
    if (!rst_n) begin
      m_ready = 0; m_rd = 0; m_wr = 0; m_busy = 0; m_ar = 0; m_aw = 0; m_w = 0;
`ifdef MEM_AXI_ERR_CAPTURE_EN
      m_ev = 0; m_wq.delete();
`endif
    end
    rlast_hs = m_ready && axi_rvalid && axi_rlast && (m_rd > 0);
    bhs      = m_ready && axi_bvalid && (m_wr > 0);
    rcred    = (m_rd - int'(rlast_hs)) < MAX_READS;
    wcred    = (m_wr - int'(bhs)) < MAX_WRITES;
    e_ack    = m_ready && mem_request && (m_busy == 0) && (mem_rnw ? rcred : wcred);

    chk("ack", mem_ack, e_ack);
    chk("rready", axi_rready, m_ready);
    chk("bready", axi_bready, m_ready);
    chk("mem_rvalid", mem_rvalid, m_ready && axi_rvalid);
    if (m_ready && axi_rvalid) begin
      chk("mem_rdata", mem_rdata, axi_rdata);
      chk("mem_rid", mem_rid, axi_rid[1:0]);
    end
    chk("arvalid", axi_arvalid, m_ar);
    if (m_ar) begin
      chk("araddr", axi_araddr, {m_addr, 2'b00});
      chk("arlen", axi_arlen, {3'b000, m_rlen});
      chk("arid", axi_arid, {4'b0000, m_id});
      chk("arlock", axi_arlock, m_rmw);
      chk("ar_fixed", {axi_arsize, axi_arburst, axi_arcache}, {3'b010, 2'b01, 4'b0011});
    end
    chk("awvalid", axi_awvalid, m_aw);
    chk("wvalid", axi_wvalid, m_w);
    if (m_aw) begin
      chk("awaddr", axi_awaddr, {m_addr, 2'b00});
      chk("awlock", axi_awlock, m_rmw);
      chk("aw_fixed", {axi_awlen, axi_awsize, axi_awburst, axi_awcache}, {8'd0, 3'b010, 2'b01, 4'b0011});
    end
    if (m_w) begin
      chk("wdata", axi_wdata, m_wdata);
      chk("wstrb_wlast", {axi_wstrb, axi_wlast}, {m_wbe, 1'b1});
    end
    chk("write_outstanding", mem_write_outstanding, (m_wr > 0) || (m_busy == 2));
    chk("inv", {mem_inv, mem_inv_addr}, 31'd0);
`ifdef MEM_AXI_ERR_CAPTURE_EN
    chk("err_valid", err_valid, m_ev);
    if (m_ev) chk("err_addr", err_addr, m_ea);
`endif

    if (rst_n) begin
`ifdef MEM_AXI_ERR_CAPTURE_EN
      if (err_clr) m_ev = 0;
      else if (!m_ev && m_ready && axi_rvalid && axi_rresp[1]) begin
        m_ev = 1;
        m_ea = m_rtab.exists(int'(axi_rid[1:0])) ? m_rtab[int'(axi_rid[1:0])] : 32'd0;
      end else if (!m_ev && bhs && axi_bresp[1]) begin
        m_ev = 1;
        m_ea = m_wq[0];
      end
      if (m_ar && axi_arready) m_rtab[int'(m_id)] = {m_addr, 2'b00};
      if (bhs) void'(m_wq.pop_front());
      if (e_ack && !mem_rnw) m_wq.push_back({mem_addr, 2'b00});
`endif
      if (m_ar && axi_arready) begin m_ar = 0; m_busy = 0; m_rd++; end
      if (rlast_hs) m_rd--;
      if (m_aw && axi_awready) m_aw = 0;
      if (m_w && axi_wready) m_w = 0;
      if (m_busy == 2 && !m_aw && !m_w) m_busy = 0;
      if (bhs) m_wr--;
      if (e_ack) begin
        m_addr = mem_addr; m_rlen = mem_rlen; m_rmw = mem_rmw;
        m_wbe = mem_wbe; m_wdata = mem_wdata; m_id = mem_id;
        m_busy = mem_rnw ? 1 : 2;
        m_ar = mem_rnw; m_aw = !mem_rnw; m_w = !mem_rnw;
        if (!mem_rnw) m_wr++;
      end
      m_ready = 1;
    end
  end

  initial begin
    int acks;
    // Reset with a request held: no ack.
    mem_request = 1; mem_rnw = 1;
    cyc(); cyc();
    @(negedge clk); chk("reset_ack", mem_ack, 0);
    chk("reset_valids", {axi_arvalid, axi_awvalid, axi_wvalid, mem_write_outstanding}, 4'b0);
    cyc(); rst_n = 1; mem_request = 0;
    cyc(); @(negedge clk); chk("rready_after_reset", axi_rready, 1);

    // Read burst rlen=3 id=2 at 0x1000.
    cyc(); mem_request = 1; mem_rnw = 1; mem_addr = 30'h400; mem_rlen = 5'd3; mem_id = 2'd2;
    @(negedge clk); chk("rd_ack_c0", mem_ack, 1);
    cyc(); mem_request = 0; axi_arready = 1;
    @(negedge clk); chk("rd_arvalid_c1", axi_arvalid, 1); chk("rd_araddr", axi_araddr, 32'h1000);
    chk("rd_arlen", axi_arlen, 3); chk("rd_arid", axi_arid, 2);
    cyc(); axi_arready = 0;
    @(negedge clk); chk("rd_cnt_1", dut.read_cnt, 1);
    for (int k = 0; k < 4; k++) begin
      cyc(); axi_rvalid = 1; axi_rid = 6'd2; axi_rdata = 32'hA0 + k; axi_rlast = (k == 3);
      @(negedge clk); chk("rd_beat_data", mem_rdata, 32'hA0 + k); chk("rd_beat_rid", mem_rid, 2);
    end
    cyc(); axi_rvalid = 0; axi_rlast = 0;
    @(negedge clk); chk("rd_cnt_0", dut.read_cnt, 0);

    // Write, awready 3 cycles late, wready immediate.
    cyc(); mem_request = 1; mem_rnw = 0; mem_addr = 30'h800; mem_wbe = 4'b0011;
    mem_wdata = 32'hDEADBEEF; mem_rmw = 0; axi_wready = 1;
    @(negedge clk); chk("wr_ack_c0", mem_ack, 1);
    cyc(); mem_request = 0;
    @(negedge clk); chk("wr_c1_valids", {axi_awvalid, axi_wvalid}, 2'b11);
    chk("wr_wstrb", axi_wstrb, 4'b0011); chk("wr_wdata", axi_wdata, 32'hDEADBEEF);
    cyc(); @(negedge clk); chk("wr_c2_valids", {axi_awvalid, axi_wvalid}, 2'b10);
    cyc(); @(negedge clk); chk("wr_c3_awvalid", axi_awvalid, 1);
    cyc(); axi_awready = 1;
    @(negedge clk); chk("wr_c4_awvalid", axi_awvalid, 1); chk("wr_awaddr", axi_awaddr, 32'h2000);
    cyc(); axi_awready = 0; axi_wready = 0;
    @(negedge clk); chk("wr_c5_awvalid", axi_awvalid, 0); chk("wr_outst_pre_b", mem_write_outstanding, 1);
    cyc(); axi_bvalid = 1; axi_bresp = 2'b00;
    @(negedge clk); chk("wr_outst_at_b", mem_write_outstanding, 1);
    cyc(); axi_bvalid = 0;
    @(negedge clk); chk("wr_outst_after_b", mem_write_outstanding, 0);

    // Credit limit: 5 reads, no R until the 5th is stalled.
    cyc(); mem_request = 1; mem_rnw = 1; mem_rlen = 0; mem_addr = 30'h10; mem_id = 0; axi_arready = 1;
    acks = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk); if (mem_ack) acks++;
      cyc();
    end
    chk("credit_acks", acks, 4); chk("credit_cnt", dut.read_cnt, 4);
    axi_rvalid = 1; axi_rlast = 1; axi_rid = 6'd0;
    @(negedge clk); chk("credit_ack_on_rlast", mem_ack, 1);
    cyc(); mem_request = 0; axi_rvalid = 0; axi_rlast = 0;
    cyc(); @(negedge clk); chk("credit_cnt_refill", dut.read_cnt, 4);
    for (int k = 0; k < 4; k++) begin cyc(); axi_rvalid = 1; axi_rlast = 1; end
    cyc(); axi_rvalid = 0; axi_rlast = 0;
    @(negedge clk); chk("credit_drained", dut.read_cnt, 0);

    // Same-cycle AR handshake and rlast with two outstanding.
    cyc(); mem_request = 1; mem_id = 1;
    cyc(); mem_request = 0;
    cyc(); mem_request = 1; mem_id = 3;
    cyc(); mem_request = 0;
    cyc(); mem_request = 1; mem_id = 2;
    @(negedge clk); chk("same_cnt_before", dut.read_cnt, 2);
    cyc(); mem_request = 0; axi_rvalid = 1; axi_rlast = 1; axi_rid = 6'd1;
    @(negedge clk); chk("same_arvalid", axi_arvalid, 1);
    cyc(); axi_rvalid = 0; axi_rlast = 0;
    @(negedge clk); chk("same_cnt_after", dut.read_cnt, 2);
    for (int k = 0; k < 2; k++) begin cyc(); axi_rvalid = 1; axi_rlast = 1; end
    cyc(); axi_rvalid = 0; axi_rlast = 0;

    // Exclusive write with EXOKAY, then a DECERR read at 0x2000.
    cyc(); mem_request = 1; mem_rnw = 0; mem_rmw = 1; mem_addr = 30'h900; mem_wbe = 4'hF;
    mem_wdata = 32'h12345678; axi_awready = 1; axi_wready = 1;
    cyc(); mem_request = 0;
    @(negedge clk); chk("rmw_awlock", axi_awlock, 1);
    cyc(); axi_awready = 0; axi_wready = 0;
    cyc(); axi_bvalid = 1; axi_bresp = 2'b01;
    cyc(); axi_bvalid = 0; axi_bresp = 2'b00;
`ifdef MEM_AXI_ERR_CAPTURE_EN
    @(negedge clk); chk("exokay_no_err", err_valid, 0);
`endif
    cyc(); mem_request = 1; mem_rnw = 1; mem_rmw = 0; mem_addr = 30'h800; mem_rlen = 0; mem_id = 1;
    cyc(); mem_request = 0;
    cyc(); axi_rvalid = 1; axi_rlast = 1; axi_rid = 6'd1; axi_rresp = 2'b11;
    cyc(); axi_rvalid = 0; axi_rlast = 0; axi_rresp = 2'b00;
`ifdef MEM_AXI_ERR_CAPTURE_EN
    @(negedge clk); chk("decerr_valid", err_valid, 1); chk("decerr_addr", err_addr, 32'h2000);
    cyc(); err_clr = 1;
    cyc(); err_clr = 0;
    @(negedge clk); chk("err_cleared", err_valid, 0);
`endif

    // Async reset with arvalid high and three reads outstanding.
    for (int k = 0; k < 3; k++) begin
      cyc(); mem_request = 1; mem_id = 2'(k);
      cyc(); mem_request = 0;
    end
    cyc(); axi_arready = 0; mem_request = 1;
    cyc(); mem_request = 0;
    @(negedge clk); chk("pre_rst_arvalid", axi_arvalid, 1); chk("pre_rst_cnt", dut.read_cnt, 3);
    #2; rst_n = 0; mem_request = 1; axi_rvalid = 1;
    #1; chk("rst_async_outs", {axi_arvalid, mem_ack, mem_rvalid, axi_rready, mem_write_outstanding}, 5'b0);
    chk("rst_async_cnt", dut.read_cnt, 0);
    cyc(); cyc(); rst_n = 1; mem_request = 0; axi_rvalid = 0;
    cyc(); @(negedge clk); chk("post_rst_idle", {axi_arvalid, axi_awvalid, axi_wvalid}, 3'b0);
    cyc(); mem_request = 1; mem_rnw = 1; mem_id = 0;
    @(negedge clk); chk("post_rst_ack", mem_ack, 1);
    cyc(); mem_request = 0; axi_arready = 1;
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
